fifo_sram_prefetch: RTL and testbench



---
 rtl/fifo_sram_prefetch.sv | 106 ++++++++++
 tb/tb_fifo_sram_prefetch.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sram_prefetch.sv
// Synchronous FIFO over a storage array with registered read latency.
// A small prefetch buffer hides the read latency behind a show-ahead valid/ready output.
module fifo_sram_prefetch #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned AF_TH      = 12,
    parameter int unsigned AE_TH      = 2
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    input  logic                                       up_valid_i,
    output logic                                       up_ready_o,
    input  logic [WIDTH-1:0]                           up_data_i,
    output logic                                       down_valid_o,
    input  logic                                       down_ready_i,
    output logic [WIDTH-1:0]                           down_data_o,
    output logic [$clog2(DEPTH+RD_LATENCY+3)-1:0]      count_o,
    output logic                                       almost_full_o,
    output logic                                       almost_empty_o
);
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam int unsigned PF_DEPTH = RD_LATENCY + 2;
    localparam int unsigned PW       = $clog2(PF_DEPTH + 1);
    localparam int unsigned CW       = $clog2(DEPTH + RD_LATENCY + 3);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [AW:0]           wr_ptr, rd_ptr;
    logic [PW-1:0]         inflight_cnt, pf_cnt, pf_wr, pf_rd;
    logic [WIDTH-1:0]      pf_mem [2**PW];
    logic [RD_LATENCY-1:0] pipe_vld;
    logic [WIDTH-1:0]      pipe_data [RD_LATENCY];
    logic                  full, empty, push, pop, issue, capture;

    function automatic logic [PW-1:0] pf_next(input logic [PW-1:0] p);
        return (p == PW'(PF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    // Issue is throttled on registered occupancy only, so nothing here depends on down_ready_i.
    assign issue   = !empty && (({1'b0, pf_cnt} + {1'b0, inflight_cnt}) < (PW+1)'(PF_DEPTH));
    assign capture = pipe_vld[RD_LATENCY-1];

    assign up_ready_o     = !full;
    assign push           = up_valid_i && up_ready_o;
    assign down_valid_o   = (pf_cnt != '0);
    assign pop            = down_valid_o && down_ready_i;
    assign down_data_o    = pf_mem[pf_rd];
    assign almost_full_o  = (count_o >= CW'(AF_TH));
    assign almost_empty_o = (count_o <= CW'(AE_TH));

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= up_data_i;
        end
        pipe_data[0] <= mem[rd_ptr[AW-1:0]];
        for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            pipe_data[i] <= pipe_data[i-1];
        end
        if (capture) begin
            pf_mem[pf_wr] <= pipe_data[RD_LATENCY-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            inflight_cnt <= '0;
            pf_cnt       <= '0;
            pf_wr        <= '0;
            pf_rd        <= '0;
            pipe_vld     <= '0;
            count_o      <= '0;
        end else begin
            if (push)    wr_ptr <= wr_ptr + (AW+1)'(1);
            if (issue)   rd_ptr <= rd_ptr + (AW+1)'(1);
            if (capture) pf_wr  <= pf_next(pf_wr);
            if (pop)     pf_rd  <= pf_next(pf_rd);

            pipe_vld[0] <= issue;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
            end

            case ({issue, capture})
                2'b10:   inflight_cnt <= inflight_cnt + PW'(1);
                2'b01:   inflight_cnt <= inflight_cnt - PW'(1);
                default: inflight_cnt <= inflight_cnt;
            endcase

            case ({capture, pop})
                2'b10:   pf_cnt <= pf_cnt + PW'(1);
                2'b01:   pf_cnt <= pf_cnt - PW'(1);
                default: pf_cnt <= pf_cnt;
            endcase

            case ({push, pop})
                2'b10:   count_o <= count_o + CW'(1);
                2'b01:   count_o <= count_o - CW'(1);
                default: count_o <= count_o;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_sram_prefetch.sv
// Scoreboard bench for fifo_sram_prefetch: directed scenarios plus a random valid/ready soak.
module tb_fifo_sram_prefetch;
    parameter int unsigned RD_LAT = 2;
    localparam int unsigned W   = 8;
    localparam int unsigned D   = 16;
    localparam int unsigned CAP = D + RD_LAT + 2;
    localparam int unsigned CW  = $clog2(D + RD_LAT + 3);

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          up_valid_i = 1'b0;
    logic          up_ready_o;
    logic [W-1:0]  up_data_i = '0;
    logic          down_valid_o;
    logic          down_ready_i = 1'b0;
    logic [W-1:0]  down_data_o;
    logic [CW-1:0] count_o;
    logic          almost_full_o;
    logic          almost_empty_o;

    int checks = 0;
    int errors = 0;
    int model_cnt = 0;
    logic [W-1:0] exp_q[$];

    fifo_sram_prefetch #(
        .WIDTH(W), .DEPTH(D), .RD_LATENCY(RD_LAT), .AF_TH(12), .AE_TH(2)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .up_valid_i(up_valid_i), .up_ready_o(up_ready_o), .up_data_i(up_data_i),
        .down_valid_o(down_valid_o), .down_ready_i(down_ready_i), .down_data_o(down_data_o),
        .count_o(count_o), .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: mid-cycle sampling, scoreboard pop/compare and occupancy model.
    always @(negedge clk) begin
        if (!rst_ni) begin
            exp_q.delete();
            model_cnt = 0;
        end else begin
            check("count", int'(count_o), model_cnt);
            check("almost_full", int'(almost_full_o), int'(model_cnt >= 12));
            check("almost_empty", int'(almost_empty_o), int'(model_cnt <= 2));
            if (down_valid_o && down_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected no word", down_data_o);
                end else begin
                    check("data", int'(down_data_o), int'(exp_q.pop_front()));
                end
                model_cnt--;
            end
            if (up_valid_i && up_ready_o) begin
                exp_q.push_back(up_data_i);
                model_cnt++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, acc, run, pops, first, last, pushed;

        // Reset
        rst_ni = 1'b0;
        step(); step();
        rst_ni = 1'b1;
        check("rst_up_ready", int'(up_ready_o), 1);
        check("rst_down_valid", int'(down_valid_o), 0);
        check("rst_count", int'(count_o), 0);
        check("rst_almost_full", int'(almost_full_o), 0);
        check("rst_almost_empty", int'(almost_empty_o), 1);

        // 1: single word latency
        up_valid_i = 1'b1; up_data_i = 8'hA5; down_ready_i = 1'b1;
        step();
        up_valid_i = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            if (down_valid_o) begin
                lat = k;
                break;
            end
            step();
        end
        check("first_latency", lat, RD_LAT + 2);
        step(); step();

        // 2: fill to capacity with consumer stalled
        down_ready_i = 1'b0;
        acc = 0;
        for (int k = 0; k < 200 && acc < CAP; k++) begin
            up_valid_i = 1'b1;
            up_data_i  = W'(acc);
            if (up_ready_o) acc++;
            step();
        end
        check("fill_accepted", acc, CAP);
        up_data_i = 8'hEE;
        for (int k = 0; k < 5; k++) step();
        check("full_up_ready", int'(up_ready_o), 0);
        check("full_count", int'(count_o), CAP);
        check("full_almost_full", int'(almost_full_o), 1);
        up_valid_i = 1'b0;

        // 3: drain without gaps
        down_ready_i = 1'b1;
        run = 0;
        while (down_valid_o && run < CAP + 10) begin
            run++;
            step();
        end
        check("drain_run", run, CAP);
        step();
        check("drain_down_valid", int'(down_valid_o), 0);
        check("drain_count", int'(count_o), 0);

        // 4: streaming 100 words, pointers wrap several times
        pops = 0; first = -1; last = -1;
        for (int k = 0; k < 400 && pops < 100; k++) begin
            up_valid_i = (k < 100);
            up_data_i  = W'(k);
            if (down_valid_o) begin
                if (first < 0) first = k;
                last = k;
                pops++;
            end
            step();
        end
        up_valid_i = 1'b0;
        check("stream_pops", pops, 100);
        check("stream_span", last - first + 1, 100);

        // 5: random valid/ready
        pushed = 0;
        for (int k = 0; k < 20000 && pushed < 1000; k++) begin
            up_valid_i   = 1'($urandom_range(0, 1));
            up_data_i    = W'($urandom);
            down_ready_i = 1'($urandom_range(0, 1));
            if (up_valid_i && up_ready_o) pushed++;
            step();
        end
        check("random_pushed", pushed, 1000);
        up_valid_i = 1'b0; down_ready_i = 1'b1;
        for (int k = 0; k < 200 && (down_valid_o || count_o != 0); k++) step();
        step();
        check("random_drained", exp_q.size(), 0);
        check("random_count", int'(count_o), 0);

        // 6: reset with words held and reads in flight
        down_ready_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            up_valid_i = 1'b1;
            up_data_i  = W'(8'h30 + k);
            step();
        end
        up_valid_i = 1'b0;
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        check("mid_rst_count", int'(count_o), 0);
        check("mid_rst_down_valid", int'(down_valid_o), 0);
        check("mid_rst_up_ready", int'(up_ready_o), 1);
        down_ready_i = 1'b1;
        run = 0;
        for (int k = 0; k < RD_LAT + 4; k++) begin
            if (down_valid_o) run++;
            step();
        end
        check("stale_words", run, 0);
        for (int k = 0; k < 3; k++) begin
            up_valid_i = 1'b1;
            up_data_i  = W'(8'hC0 + k);
            step();
        end
        up_valid_i = 1'b0;
        for (int k = 0; k < 20; k++) step();
        check("post_rst_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
